multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that turns the single-cycle RISC-V datapath into a multicycle one sharing one memory port for instruction fetch and data access. Decodes `opcode`/`funct3` from the instruction register and drives every datapath enable and mux select, one state per cycle. Sits beside the program counter, register file, ALU, sign extender and unified memory inside `processor`. Handles variable memory latency through a `mem_req`/`mem_ready` handshake.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `opcode` input 7: instr[6:0] from the instruction register.
- `funct3` input 3: instr[14:12].
- `zero` input 1: ALU result == 0.
- `mem_ready` input 1: memory completed the current access this cycle.
- `mem_req` output 1: memory access requested.
- `mem_write` output 1: the requested access is a store.
- `adr_src` output 1: 0 = PC, 1 = ALU-out register.
- `ir_write`, `pc_write`, `reg_write` output 1 each: register enables.
- `alu_src_a` output 2: 00 PC, 01 old PC, 10 rs1.
- `alu_src_b` output 2: 00 rs2, 01 immediate, 10 constant 4.
- `alu_op` output 2: 00 add, 01 subtract, 10 decode from funct3/funct7.
- `result_src` output 2: 00 ALU-out register, 01 memory data, 10 ALU result.
- `imm_src` output 3: 000 I, 001 S, 010 B, 011 J.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `trap` output 1: illegal-instruction halt (see Configuration).

## Operation
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-ALU, 0010011 I-ALU, 1100011 branch, 1101111 jal.
- Outputs are a Moore decode of the state register. Exceptions: `pc_write` in BRANCH, and gating by `mem_ready`. Any signal not listed for a state is 0.
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). `imm_src` is set by opcode: lw/I-ALU→000, sw→001, branch→010, jal→011. Next state: lw/sw→MEMADR, R→EXEC_R, I→EXEC_I, branch→BRANCH, jal→JAL, other→ILLEGAL.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00, `imm_src` as in DECODE. lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Holds until `mem_ready`. On `mem_ready`: `instr_done`=1, go to FETCH. The memory writes exactly once, in the `mem_ready` cycle.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, `imm_src`=000. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `instr_done`=1. Goes to FETCH.
  - `pc_write` = (`funct3`==000 & `zero`) | (`funct3`==001 & !`zero`).
  - Any other `funct3`: not taken.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Goes to ALUWB, which writes rd = old PC + 4.

## Timing
- Reset: state = FETCH. While `rst` is high, every output is 0, including `mem_req`, `trap` and `instr_done`.
- Reset asserted mid-instruction, including during a pending memory wait: the access is abandoned; the next cycle is FETCH with no writes.
- Cycles per instruction with zero wait states:
  - lw 5
  - sw 4
  - R-ALU 4
  - I-ALU 4
  - jal 4
  - branch 3
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_req`, `mem_write` and `adr_src` stay stable throughout a wait.
- `mem_ready` outside a requesting state is ignored.
- `instr_done` is high for exactly one cycle per retired instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - The ILLEGAL state is the TRAP state: all enables 0, `trap`=1.
  - It stays there until `rst`, with no further `mem_req`.
- Macro undefined:
  - ILLEGAL asserts `instr_done`=1 and returns to FETCH. The instruction acts as a NOP, since PC+4 was already written in FETCH.
  - `trap` is tied to 0.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state encoding (4-bit enum);
  - opcode constants;
  - `alu_op`, `alu_src_a`/`alu_src_b`, `result_src` and `imm_src` encodings.
- One natural sub-module, `imm_src_decode`: the combinational opcode → `imm_src` map, shared by DECODE and MEMADR.
- Everything else lives in one FSM file: a state register plus next-state and output logic.

## Test plan
- Reset, then release with `mem_ready`=1, opcode 0110011 → states FETCH, DECODE, EXEC_R, ALUWB. `reg_write`=1 only in cycle 4; `instr_done` pulses in cycle 4.
- lw with `mem_ready` held low 2 cycles in MEMREAD → 7 total cycles, `mem_req`=1 and `adr_src`=1 stable throughout the wait, `reg_write`=1 only in MEMWB.
- sw with `mem_ready`=1 → `mem_write`=1 for exactly 1 cycle, `reg_write` never asserted, retires in cycle 4.
- beq with `zero`=1, then bne with `zero`=1 → `pc_write`=1 in BRANCH for beq, 0 for bne; each takes 3 cycles.
- jal → `pc_write`=1 in JAL, then ALUWB with `reg_write`=1, `result_src`=00; 4 cycles total.
- Opcode 1111111 → with the macro: `trap`=1 held and no `mem_req` for 20 cycles. Without it: `instr_done`=1 in cycle 3, then FETCH. `rst` asserted mid-MEMREAD → FETCH next cycle with all enables 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Holds the controller state encoding, the opcodes the controller
// recognises, and the encodings of every datapath mux select and ALU
// operation class it drives.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/imm_src_decode.sv
// Opcode to immediate-format map used by the sign extender.
// Ports:
//   opcode  in  7  instruction opcode field
//   imm_src out 3  immediate format (I, S, B, J)
module imm_src_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src
);

  // Loads, I-type ALU ops and anything unrecognised fall back to the
  // I format; only stores, branches and jal need a different layout.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:     imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RISC-V datapath with one shared memory
// port. One state per cycle; outputs are decoded from the state register,
// except pc_write in BRANCH and the mem_ready-gated enables.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct3      fields of the instruction register
//   zero                ALU result equals zero
//   mem_ready           memory completes the current access this cycle
//   mem_req, mem_write  memory access request and store qualifier
//   adr_src             memory address: 0 PC, 1 ALU-out register
//   ir_write, pc_write, reg_write   register enables
//   alu_src_a, alu_src_b, alu_op    ALU operand selects and operation class
//   result_src, imm_src             result mux and immediate format
//   instr_done          one-cycle pulse on instruction retirement
//   trap                illegal-instruction halt indicator
//
// Build option: MC_ILLEGAL_TRAP_EN makes an unknown opcode halt in the
// ILLEGAL state with trap high until reset. Without it, an unknown opcode
// retires as a NOP and trap is always 0.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       trap
);

  state_t     state;
  state_t     state_next;
  logic [2:0] dec_imm_src;
  logic       branch_taken;

  imm_src_decode u_imm_src_decode (
    .opcode  (opcode),
    .imm_src (dec_imm_src)
  );

  // Only beq and bne are supported; every other funct3 falls through.
  assign branch_taken = ((funct3 == F3_BEQ) &&  zero) ||
                        ((funct3 == F3_BNE) && !zero);

  // State register. Reset abandons whatever access was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. mem_ready is looked at only in the three states
  // that actually hold a memory request.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXEC_R;
          OP_I:         state_next = EXEC_I;
          OP_BRANCH:    state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_SW) state_next = MEMWRITE;
        else                 state_next = MEMREAD;
      end
      MEMREAD: begin
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB:    state_next = FETCH;
      MEMWRITE: begin
        if (mem_ready) state_next = FETCH;
      end
      EXEC_R:   state_next = ALUWB;
      EXEC_I:   state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL:  state_next = ILLEGAL;
`else
      ILLEGAL:  state_next = FETCH;
`endif
      default:  state_next = FETCH;
    endcase
  end

  // Output decode. Everything defaults to 0 and stays 0 while rst is
  // high, so a reset in the middle of a memory wait drops the request in
  // the same cycle instead of one cycle later.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_OP_ADD;
    result_src = RES_ALU_OUT;
    imm_src    = IMM_I;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          adr_src    = 1'b0;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          alu_op     = ALU_OP_ADD;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_ADD;
          imm_src   = dec_imm_src;
        end
        MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_ADD;
          imm_src   = dec_imm_src;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = RES_MEM_DATA;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALU_OP_FUNCT;
        end
        EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_FUNCT;
          imm_src   = IMM_I;
        end
        ALUWB: begin
          result_src = RES_ALU_OUT;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALU_OP_SUB;
          result_src = RES_ALU_OUT;
          pc_write   = branch_taken;
          instr_done = 1'b1;
        end
        JAL: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          alu_op     = ALU_OP_ADD;
          result_src = RES_ALU_OUT;
          pc_write   = 1'b1;
        end
        ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
          trap       = 1'b1;
`else
          instr_done = 1'b1;
`endif
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Every cycle compares the
// full packed control word against a hand-written expected word.
// Honours MC_ILLEGAL_TRAP_EN to pick the expected illegal-opcode behaviour.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       instr_done, trap;

  int checks = 0;
  int errors = 0;

  logic [18:0] obs;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .imm_src    (imm_src),
    .instr_done (instr_done),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  // Control word order: req wr adr irw pcw rw a b op res imm done trap
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, imm_src,
                instr_done, trap};

  function automatic logic [18:0] ctl(
    input logic req, input logic wr, input logic adr, input logic irw,
    input logic pcw, input logic rw, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] op, input logic [1:0] res, input logic [2:0] imm,
    input logic done, input logic trp);
    ctl = {req, wr, adr, irw, pcw, rw, a, b, op, res, imm, done, trp};
  endfunction

  task automatic checkOutput(input string tag, input logic [18:0] got,
                             input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of handshake inputs, compare mid-cycle, then step
  // just past the next rising edge.
  task automatic applyStimulus(input string tag, input logic rdy,
                               input logic z, input logic [18:0] exp);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    checkOutput(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  logic [18:0] idle_w, fetch_go, fetch_wait, exec_r, exec_i, aluwb, memread;
  logic [18:0] memwb, memwr_wait, memwr_go, br_t, br_n, jal_w, ill_w;

  function automatic logic [18:0] dec_w(input logic [2:0] imm);
    dec_w = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,imm,1'b0,1'b0);
  endfunction

  function automatic logic [18:0] madr_w(input logic [2:0] imm);
    madr_w = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,imm,1'b0,1'b0);
  endfunction

  initial begin
    idle_w     = 19'd0;
    fetch_go   = ctl(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b00,2'b10,3'b000,1'b0,1'b0);
    fetch_wait = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,3'b000,1'b0,1'b0);
    exec_r     = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,3'b000,1'b0,1'b0);
    exec_i     = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,3'b000,1'b0,1'b0);
    aluwb      = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0);
    memread    = ctl(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0);
    memwb      = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,3'b000,1'b1,1'b0);
    memwr_wait = ctl(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0);
    memwr_go   = ctl(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0);
    br_t       = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,2'b00,3'b000,1'b1,1'b0);
    br_n       = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,3'b000,1'b1,1'b0);
    jal_w      = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,2'b00,3'b000,1'b0,1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    ill_w      = 19'd1;
`else
    ill_w      = 19'd2;
`endif

    rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b0;

    // Reset: all outputs low even with mem_ready high
    applyStimulus("rst_a", 1'b1, 1'b0, idle_w);
    applyStimulus("rst_b", 1'b1, 1'b0, idle_w);
    rst = 1'b0;

    // R-type: FETCH DECODE EXEC_R ALUWB
    opcode = 7'b0110011; funct3 = 3'b000;
    applyStimulus("r_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("r_decode", 1'b1, 1'b0, dec_w(3'b000));
    applyStimulus("r_exec",   1'b1, 1'b0, exec_r);
    applyStimulus("r_wb",     1'b1, 1'b0, aluwb);

    // lw with two wait cycles in MEMREAD: 7 cycles total
    opcode = 7'b0000011; funct3 = 3'b010;
    applyStimulus("lw_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("lw_decode", 1'b1, 1'b0, dec_w(3'b000));
    applyStimulus("lw_madr",   1'b1, 1'b0, madr_w(3'b000));
    applyStimulus("lw_wait1",  1'b0, 1'b0, memread);
    applyStimulus("lw_wait2",  1'b0, 1'b0, memread);
    applyStimulus("lw_read",   1'b1, 1'b0, memread);
    applyStimulus("lw_wb",     1'b1, 1'b0, memwb);

    // sw, no wait: retires in cycle 4
    opcode = 7'b0100011;
    applyStimulus("sw_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("sw_decode", 1'b1, 1'b0, dec_w(3'b001));
    applyStimulus("sw_madr",   1'b1, 1'b0, madr_w(3'b001));
    applyStimulus("sw_write",  1'b1, 1'b0, memwr_go);

    // Branches: beq z=1 taken, bne z=1 not, bne z=0 taken, beq z=0 not, blt not
    opcode = 7'b1100011;
    funct3 = 3'b000;
    applyStimulus("beq1_fetch",  1'b1, 1'b1, fetch_go);
    applyStimulus("beq1_decode", 1'b1, 1'b1, dec_w(3'b010));
    applyStimulus("beq1_br",     1'b1, 1'b1, br_t);
    funct3 = 3'b001;
    applyStimulus("bne1_fetch",  1'b1, 1'b1, fetch_go);
    applyStimulus("bne1_decode", 1'b1, 1'b1, dec_w(3'b010));
    applyStimulus("bne1_br",     1'b1, 1'b1, br_n);
    applyStimulus("bne0_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("bne0_decode", 1'b1, 1'b0, dec_w(3'b010));
    applyStimulus("bne0_br",     1'b1, 1'b0, br_t);
    funct3 = 3'b000;
    applyStimulus("beq0_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("beq0_decode", 1'b1, 1'b0, dec_w(3'b010));
    applyStimulus("beq0_br",     1'b1, 1'b0, br_n);
    funct3 = 3'b100;
    applyStimulus("blt_fetch",   1'b1, 1'b1, fetch_go);
    applyStimulus("blt_decode",  1'b1, 1'b1, dec_w(3'b010));
    applyStimulus("blt_br",      1'b1, 1'b1, br_n);

    // jal: FETCH DECODE JAL ALUWB
    opcode = 7'b1101111; funct3 = 3'b000;
    applyStimulus("jal_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("jal_decode", 1'b1, 1'b0, dec_w(3'b011));
    applyStimulus("jal_jal",    1'b1, 1'b0, jal_w);
    applyStimulus("jal_wb",     1'b1, 1'b0, aluwb);

    // I-type with one fetch wait; mem_ready low outside FETCH is ignored
    opcode = 7'b0010011;
    applyStimulus("i_fetchw",  1'b0, 1'b0, fetch_wait);
    applyStimulus("i_fetch",   1'b1, 1'b0, fetch_go);
    applyStimulus("i_decode",  1'b0, 1'b0, dec_w(3'b000));
    applyStimulus("i_exec",    1'b0, 1'b0, exec_i);
    applyStimulus("i_wb",      1'b0, 1'b0, aluwb);

    // sw with one wait: mem_write held, retires only on ready
    opcode = 7'b0100011;
    applyStimulus("sww_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("sww_decode", 1'b1, 1'b0, dec_w(3'b001));
    applyStimulus("sww_madr",   1'b1, 1'b0, madr_w(3'b001));
    applyStimulus("sww_wait",   1'b0, 1'b0, memwr_wait);
    applyStimulus("sww_write",  1'b1, 1'b0, memwr_go);

    // Reset during a pending MEMREAD wait
    opcode = 7'b0000011;
    applyStimulus("lwr_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("lwr_decode", 1'b1, 1'b0, dec_w(3'b000));
    applyStimulus("lwr_madr",   1'b1, 1'b0, madr_w(3'b000));
    applyStimulus("lwr_wait",   1'b0, 1'b0, memread);
    rst = 1'b1;
    applyStimulus("lwr_rst",    1'b1, 1'b0, idle_w);
    rst = 1'b0;
    applyStimulus("lwr_refetchw", 1'b0, 1'b0, fetch_wait);
    applyStimulus("lwr_refetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("lwr_decode2",  1'b1, 1'b0, dec_w(3'b000));
    applyStimulus("lwr_madr2",    1'b1, 1'b0, madr_w(3'b000));
    applyStimulus("lwr_read2",    1'b1, 1'b0, memread);
    applyStimulus("lwr_wb2",      1'b1, 1'b0, memwb);

    // Illegal opcode
    opcode = 7'b1111111;
    applyStimulus("ill_fetch",  1'b1, 1'b0, fetch_go);
    applyStimulus("ill_decode", 1'b1, 1'b0, dec_w(3'b000));
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      applyStimulus("ill_trap", 1'b1, 1'b0, ill_w);
    end
    rst = 1'b1;
    applyStimulus("ill_rst", 1'b1, 1'b0, idle_w);
    rst = 1'b0;
    applyStimulus("ill_refetch", 1'b1, 1'b0, fetch_go);
`else
    applyStimulus("ill_nop",     1'b1, 1'b0, ill_w);
    applyStimulus("ill_refetch", 1'b1, 1'b0, fetch_go);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
